// File: rtl/readout_fifo_arbiter.sv
// Round-robin burst read scheduler sharing one frame-builder port among NUM
// readout FIFOs; tags returned words with valid / start / end-of-burst markers.
module readout_fifo_arbiter #(
   parameter int unsigned NUM   = 4,
   parameter int unsigned ID_W  = 2,
   parameter int unsigned WIDTH = 7,
   parameter int unsigned BURST = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM-1:0]         empty,
   input  logic [NUM*WIDTH-1:0]   wordCount,
   input  logic                   outReady,
   output logic [NUM-1:0]         rden,
   output logic [ID_W-1:0]        grantId,
   output logic                   dataValid,
   output logic                   sof,
   output logic                   eof,
   output logic [WIDTH-1:0]       burstLen,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, GRANT, READ, GAP} state_t;

   localparam logic [WIDTH-1:0] BURST_W = WIDTH'(BURST);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [ID_W:0]    NUM_W   = (ID_W+1)'(NUM);

   state_t           state, nextState;
   logic [ID_W-1:0]  ptr, selId;
   logic [ID_W:0]    sum;
   logic             found;
   logic [WIDTH-1:0] selCount, selTarget, target, count;
   logic             grantEmpty, readOk, lastRead;

   // First non-empty FIFO searching ptr, ptr+1, ... with wrap at NUM.
   always_comb begin
      found = 1'b0;
      selId = '0;
      sum   = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(k);
         if (sum >= NUM_W)
            sum = sum - NUM_W;
         if (!found && !empty[sum[ID_W-1:0]]) begin
            found = 1'b1;
            selId = sum[ID_W-1:0];
         end
      end
   end

   always_comb begin
      selCount  = wordCount[selId*WIDTH +: WIDTH];
      selTarget = (selCount == '0 || selCount > BURST_W) ? BURST_W : selCount;
   end

   assign grantEmpty = empty[grantId];
   assign readOk     = (state == READ) && outReady && !grantEmpty && (count < target);
   assign lastRead   = readOk && ((count + ONE) == target);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (enable && found) nextState = GRANT;
         GRANT:   nextState = READ;
         READ:    if (grantEmpty || lastRead) nextState = GAP;
         GAP:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      rden          = '0;
      rden[grantId] = readOk;
      busy          = (state != IDLE);
   end

   // count doubles as burstLen: both clear on selection and step on each read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         grantId   <= '0;
         target    <= '0;
         count     <= '0;
         dataValid <= 1'b0;
         sof       <= 1'b0;
         eof       <= 1'b0;
      end else begin
         dataValid <= readOk;
         sof       <= readOk && (count == '0);
         eof       <= (state == READ) && (grantEmpty || lastRead);
         case (state)
            IDLE: begin
               if (enable && found) begin
                  grantId <= selId;
                  target  <= selTarget;
                  count   <= '0;
               end
            end
            READ: begin
               if (readOk)
                  count <= count + ONE;
            end
            GAP: begin
               ptr <= (grantId == ID_W'(NUM-1)) ? '0 : grantId + ID_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign burstLen = count;

endmodule

// File: tb/tb_readout_fifo_arbiter.sv
// Directed bench for readout_fifo_arbiter: FIFO occupancy model drives the flags,
// a cycle model derived from the scheduling rules checks every output each cycle.
module tb_readout_fifo_arbiter;

   localparam int NUM   = 4;
   localparam int ID_W  = 2;
   localparam int WIDTH = 7;
   localparam int BURST = 16;

   localparam int S_IDLE  = 0;
   localparam int S_GRANT = 1;
   localparam int S_READ  = 2;
   localparam int S_GAP   = 3;

   logic                 clk = 1'b0;
   logic                 reset, enable, outReady;
   logic [NUM-1:0]       empty, rden;
   logic [NUM*WIDTH-1:0] wordCount;
   logic [ID_W-1:0]      grantId;
   logic                 dataValid, sof, eof, busy;
   logic [WIDTH-1:0]     burstLen;

   always #5 clk = ~clk;

   readout_fifo_arbiter #(.NUM(NUM), .ID_W(ID_W), .WIDTH(WIDTH), .BURST(BURST)) dut (
      .clk(clk), .reset(reset), .enable(enable), .empty(empty), .wordCount(wordCount),
      .outReady(outReady), .rden(rden), .grantId(grantId), .dataValid(dataValid),
      .sof(sof), .eof(eof), .burstLen(burstLen), .busy(busy)
   );

   // FIFO environment: level = words pushed by the stimulus minus words popped by rden.
   int pushed[NUM] = '{default: 0};
   int popped[NUM] = '{default: 0};
   bit wcOff[NUM]  = '{default: 1'b0};
   int lvl;

   always_comb begin
      empty     = '0;
      wordCount = '0;
      lvl       = 0;
      for (int i = 0; i < NUM; i++) begin
         lvl      = pushed[i] - popped[i];
         empty[i] = (lvl == 0);
         wordCount[i*WIDTH +: WIDTH] = wcOff[i] ? '0 : (lvl > 127 ? 7'd127 : WIDTH'(lvl));
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NUM; i++)
         if (rden[i]) popped[i] <= popped[i] + 1;
   end

   // Reference model
   int mStage, mPtr, mGid, mCnt, mTarget;
   bit mDv, mSof, mEof;

   function automatic logic [NUM-1:0] expRden();
      logic [NUM-1:0] r = '0;
      if (mStage == S_READ && outReady && !empty[mGid] && mCnt < mTarget)
         r[mGid] = 1'b1;
      return r;
   endfunction

   function automatic int pick();
      for (int k = 0; k < NUM; k++)
         if (!empty[(mPtr + k) % NUM]) return (mPtr + k) % NUM;
      return -1;
   endfunction

   function automatic int tgtOf(int i);
      int wc = int'(wordCount[i*WIDTH +: WIDTH]);
      if (wc == 0) return BURST;
      return (wc < BURST) ? wc : BURST;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mStage <= S_IDLE; mPtr <= 0; mGid <= 0; mCnt <= 0; mTarget <= 0;
         mDv <= 1'b0; mSof <= 1'b0; mEof <= 1'b0;
      end else begin
         mDv  <= |expRden();
         mSof <= (|expRden()) && (mCnt == 0);
         mEof <= 1'b0;
         case (mStage)
            S_IDLE:
               if (enable && pick() >= 0) begin
                  mGid <= pick(); mTarget <= tgtOf(pick()); mCnt <= 0; mStage <= S_GRANT;
               end
            S_GRANT: mStage <= S_READ;
            S_READ:
               if (empty[mGid]) begin
                  mStage <= S_GAP; mEof <= 1'b1;
               end else if (|expRden()) begin
                  mCnt <= mCnt + 1;
                  if (mCnt + 1 == mTarget) begin
                     mStage <= S_GAP; mEof <= 1'b1;
                  end
               end
            default: begin
               mPtr <= (mGid + 1) % NUM; mStage <= S_IDLE;
            end
         endcase
      end
   end

   // Hand-computed expectations queued by the stimulus, checked by the compare process.
   string litName[$];
   int    litAct[$];
   int    litExp[$];
   bit    done = 1'b0;
   int    nVec = 0;
   int    nBad = 0;

   task automatic lit(input string n, input int a, input int e);
      litName.push_back(n); litAct.push_back(a); litExp.push_back(e);
   endtask

   task automatic chk(input string n, input int a, input int e);
      nVec++;
      if (a != e) begin
         nBad++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("rden", int'(rden), int'(expRden()));
         chk("grantId", int'(grantId), mGid);
         chk("dataValid", int'(dataValid), int'(mDv));
         chk("sof", int'(sof), int'(mSof));
         chk("eof", int'(eof), int'(mEof));
         chk("burstLen", int'(burstLen), mCnt);
         chk("busy", int'(busy), int'(mStage != S_IDLE));
         while (litName.size() > 0)
            chk(litName.pop_front(), litAct.pop_front(), litExp.pop_front());
         if (done) begin
            $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
            $finish;
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // Per-window observation statistics
   int oRden, oFirstRden, oSof, oFirstSof, oEof, oLastEof, oEofDv, oStall, oBusy, oLastLen;
   int gapMin, gapMax, run;
   bit seenOn;
   int sofGid[$];
   int eofLen[$];

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic observe(input int n, input logic [63:0] rdyPat, input logic [63:0] enPat,
                          input bit useEn);
      oRden = 0; oFirstRden = -1; oSof = 0; oFirstSof = -1; oEof = 0; oLastEof = -1;
      oEofDv = -1; oStall = 0; oBusy = 0; oLastLen = -1;
      gapMin = 1000; gapMax = -1; run = 0; seenOn = 1'b0;
      sofGid.delete(); eofLen.delete();
      for (int t = 1; t <= n; t++) begin
         @(posedge clk); #2;
         outReady = (t < 64) ? rdyPat[t] : 1'b1;
         if (useEn) enable = (t < 64) ? enPat[t] : 1'b0;
         #1;
         if (|rden) begin
            oRden++;
            if (oFirstRden < 0) oFirstRden = t;
            if (seenOn && run > 0) begin
               if (run < gapMin) gapMin = run;
               if (run > gapMax) gapMax = run;
            end
            run = 0; seenOn = 1'b1;
            if (!outReady) oStall++;
         end else begin
            run++;
         end
         if (sof) begin
            oSof++;
            if (oFirstSof < 0) oFirstSof = t;
            sofGid.push_back(int'(grantId));
         end
         if (eof) begin
            oEof++; oLastEof = t; oEofDv = int'(dataValid); oLastLen = int'(burstLen);
            eofLen.push_back(int'(burstLen));
         end
         if (busy) oBusy++;
      end
   endtask

   function automatic int qAt(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   localparam logic [63:0] ALL1 = '1;
   localparam logic [63:0] ALL0 = '0;

   initial begin
      reset = 1'b1; enable = 1'b0; outReady = 1'b1;
      tick(); tick();
      lit("rst_busy", int'(busy), 0);
      lit("rst_grantId", int'(grantId), 0);
      lit("rst_burstLen", int'(burstLen), 0);
      reset = 1'b0;
      tick();

      // Single FIFO, 5 words
      enable = 1'b1;
      pushed[0] += 5;
      observe(12, ALL1, ALL0, 1'b0);
      lit("s1_first_rden", oFirstRden, 2);
      lit("s1_rden_cnt", oRden, 5);
      lit("s1_sof_at", oFirstSof, 3);
      lit("s1_eof_at", oLastEof, 7);
      lit("s1_eof_dv", oEofDv, 1);
      lit("s1_burstLen", oLastLen, 5);

      // All four FIFOs with 40 words each, starting from ptr 0
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < NUM; i++) pushed[i] += 40;
      observe(215, ALL1, ALL0, 1'b0);
      lit("s2_rden_cnt", oRden, 160);
      lit("s2_eof_cnt", oEof, 12);
      for (int i = 0; i < 5; i++) lit("s2_grant_seq", qAt(sofGid, i), i % NUM);
      lit("s2_len_first", qAt(eofLen, 0), 16);
      lit("s2_len_eighth", qAt(eofLen, 7), 16);
      lit("s2_len_ninth", qAt(eofLen, 8), 8);
      lit("s2_gap_min", gapMin, 3);
      lit("s2_gap_max", gapMax, 3);

      // wordCount disabled, FIFO runs empty after 3 words
      wcOff[1] = 1'b1;
      pushed[1] += 3;
      observe(10, ALL1, ALL0, 1'b0);
      wcOff[1] = 1'b0;
      lit("s3_rden_cnt", oRden, 3);
      lit("s3_eof_cnt", oEof, 1);
      lit("s3_eof_at", oLastEof, 6);
      lit("s3_eof_dv", oEofDv, 0);
      lit("s3_burstLen", oLastLen, 3);
      lit("s3_sof_cnt", oSof, 1);

      // outReady 1,0,0,1 during a 4-word burst
      pushed[2] += 4;
      observe(12, 64'hFFFF_FFFF_FFFF_FFE7, ALL0, 1'b0);
      lit("s4_rden_cnt", oRden, 4);
      lit("s4_read_while_stalled", oStall, 0);
      lit("s4_eof_at", oLastEof, 8);
      lit("s4_eof_dv", oEofDv, 1);
      lit("s4_burstLen", oLastLen, 4);
      lit("s4_busy_cycles", oBusy, 8);

      // Reset on the third cycle of a 10-word burst
      pushed[0] += 10;
      tick(); tick(); tick(); tick();
      lit("s5_pre_busy", int'(busy), 1);
      lit("s5_pre_dv", int'(dataValid), 1);
      reset = 1'b1;
      #1;
      lit("s5_rst_rden", int'(rden), 0);
      lit("s5_rst_dv", int'(dataValid), 0);
      lit("s5_rst_sof", int'(sof), 0);
      lit("s5_rst_eof", int'(eof), 0);
      lit("s5_rst_busy", int'(busy), 0);
      pushed[0] = popped[0];
      pushed[2] += 2;
      pushed[3] += 2;
      tick();
      reset = 1'b0;
      observe(20, ALL1, ALL0, 1'b0);
      lit("s5_first_grant", qAt(sofGid, 0), 2);
      lit("s5_second_grant", qAt(sofGid, 1), 3);
      lit("s5_eof_cnt", oEof, 2);

      // enable low holds off arbitration; dropping it mid-burst does not abort
      enable = 1'b0;
      pushed[1] += 4;
      observe(10, ALL1, ALL0, 1'b1);
      lit("s6_idle_rden", oRden, 0);
      lit("s6_idle_busy", oBusy, 0);
      enable = 1'b1;
      observe(12, ALL1, ALL0, 1'b1);
      lit("s6_rden_cnt", oRden, 4);
      lit("s6_eof_cnt", oEof, 1);
      lit("s6_burstLen", oLastLen, 4);
      lit("s6_grant", qAt(sofGid, 0), 1);

      tick(); tick(); tick();
      done = 1'b1;
   end

endmodule

// File: doc/readout_fifo_arbiter.md
# readout_fifo_arbiter

Round-robin read scheduler that shares one downstream frame-builder port among NUM pixel-group readout FIFOs, each built on the DDR FIFO write/read controller. It picks a non-empty FIFO, pulses that FIFO's `rden` for a bounded burst sized from its word count, and tags the returned words with valid, start-of-burst and end-of-burst markers. It sits between the FIFO controllers and the serializer frame builder in the ETROC2 readout path.

## Interface
- `NUM`, 4: number of FIFOs served; must be ≤ 2^ID_W.
- `ID_W`, 2: width of `grantId`.
- `WIDTH`, 7: FIFO address / word-count width.
- `BURST`, 16: maximum words per grant; 1 ≤ BURST ≤ 2^WIDTH−1.

Ports:
- `clk`  in  1  40 MHz readout clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable`  in  1  arbitration enable, sampled only in IDLE.
- `empty`  in  NUM  per-FIFO empty flag; bit i belongs to FIFO i.
- `wordCount`  in  NUM*WIDTH  packed counts; FIFO i at bits [i*WIDTH +: WIDTH]; 0 means count disabled or FIFO empty.
- `outReady`  in  1  downstream can accept a word in the next cycle.
- `rden`  out  NUM  one-hot or all-zero read enable to the FIFOs; combinational from state.
- `grantId`  out  ID_W  index of the FIFO currently or last granted.
- `dataValid`  out  1  FIFO read data valid; equals OR(`rden`) delayed 1 cycle.
- `sof`  out  1  with the first `dataValid` of a burst.
- `eof`  out  1  end of burst; registered.
- `burstLen`  out  WIDTH  words read in the current or last burst.
- `busy`  out  1  high in GRANT, READ and GAP.

## Operation
- States: IDLE, GRANT, READ, GAP. Reset → IDLE; `ptr`=0, `grantId`=0, `burstLen`=0, counter=0; all outputs 0.
- IDLE: if `enable`=1 and any `empty[i]`=0, select the first non-empty i searching ptr, ptr+1, … NUM−1, 0, … (mod NUM). Latch `grantId`=i and target = (wordCount[i]==0) ? BURST : min(wordCount[i], BURST). Clear counter and `burstLen`. Go to GRANT. Otherwise stay in IDLE.
- GRANT: one cycle with `rden`=0, so the selection registers and the FIFO flags settle. Go to READ.
- READ: `rden[grantId]` = `outReady` & ~`empty[grantId]` & (counter < target). Each asserted cycle increments the counter and `burstLen`.
  - Target reached: the cycle in which `rden` asserts with counter+1 == target → GAP.
  - Empty: `empty[grantId]`=1 while counter < target → GAP with no read in that cycle.
  - Stall: `outReady`=0 holds READ with no read and no counter change.
- GAP: one cycle with `rden`=0. Set `ptr` = (grantId+1) mod NUM, then go to IDLE.
- `enable` deasserting mid-burst has no effect; the burst completes normally.
- `sof` is registered from the first `rden` of the burst (counter==0).
- `eof` is registered.
  - Normal end: set from the `rden` with counter+1 == target, so it coincides with the last `dataValid`.
  - Empty end: set from the READ→GAP transition caused by empty, so it pulses alone with `dataValid`=0. This is a short-burst marker, and `burstLen` holds the words actually read. A burst that ends on empty before any read produces an `eof` with `burstLen`=0 and no `sof`.
- A burst of 1 word has `sof`=`eof`=`dataValid`=1 in the same cycle.
- Counter width is WIDTH bits; target ≤ BURST prevents wrap.

## Timing
- Select latency: a FIFO going non-empty in IDLE gets its first `rden` 2 cycles later (IDLE→GRANT→READ).
- Read data latency: 1 cycle from `rden` to `dataValid`.
- Maximum throughput: 1 word per cycle inside a burst. Per-burst overhead is 3 idle cycles (IDLE, GRANT, GAP).
- `outReady` is sampled in the same cycle as `rden` is generated. A word is read only when `outReady`=1 in that cycle.
- Reset asserted mid-burst: `rden`, `dataValid`, `sof`, `eof` and `busy` drop asynchronously. No `eof` is emitted, and `ptr` returns to 0.
- Fairness: after serving FIFO i, FIFO i is searched last, so a continuously non-empty FIFO waits at most NUM−1 bursts.

## Test plan
- Single FIFO 0 with wordCount=5, `outReady`=1: `rden[0]` asserts for 5 consecutive cycles starting 2 cycles after selection. `sof` comes with the first `dataValid`, `eof` with the fifth, and `burstLen`=5.
- All 4 FIFOs with wordCount=40, BURST=16: grants go 0,1,2,3,0,… with 16-word bursts, each burst separated by 3 idle cycles.
- wordCount=0 with `empty`=0, and `empty` rising after 3 reads: `rden` asserts 3 times. `eof` pulses alone with `dataValid`=0 one cycle after the empty detection, and `burstLen`=3.
- `outReady` toggled 1,0,0,1 during a 4-word burst: `rden` asserts only in cycles where `outReady`=1. The total is still 4 words, the state stays READ while stalled, and `eof` comes with the fourth word.
- Reset pulsed on the third cycle of a 10-word burst: all outputs go 0 without waiting for a clock edge. After release with FIFO 2 non-empty, selection restarts from `ptr`=0 and grants FIFO 2.
- `enable`=0 while FIFOs are non-empty: no `rden` asserts and `busy`=0. Dropping `enable` mid-burst still completes the burst with an `eof`.
